// File: rtl/herald_mac_engine.sv
// Herald MAC responder: iterative shift-add multiply / multiply-accumulate engine.
// Defining HERALD_MAC_SAT_EN makes the accumulate saturate instead of wrapping.
module herald_mac_engine #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] multiply_a,
    input  logic [WIDTH-1:0] multiply_b,
    input  logic             EN_multiply,
    output logic             RDY_multiply,
    output logic [WIDTH-1:0] get_multiply,
    input  logic             EN_get_multiply,
    output logic             RDY_get_multiply,
    input  logic [WIDTH-1:0] mac_a,
    input  logic [WIDTH-1:0] mac_b,
    input  logic             EN_mac,
    output logic             RDY_mac,
    output logic [WIDTH-1:0] get_mac,
    input  logic             EN_get_mac,
    output logic             RDY_get_mac,
    input  logic             EN_clear_accumulator,
    output logic             RDY_clear_accumulator,
    output logic             busy
);

    // Product datapath width: the full product is only needed when saturating.
`ifdef HERALD_MAC_SAT_EN
    localparam int PW = 2 * WIDTH;
    localparam int SW = 2 * WIDTH + 1;
    localparam logic [SW-1:0] SAT_MAX = {{(WIDTH + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic [SW-1:0] SAT_MIN = {{(WIDTH + 2){1'b1}}, {(WIDTH - 1){1'b0}}};
`else
    localparam int PW = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2
    } state_t;

    function automatic logic [WIDTH:0] abs_mag(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] ext;
        ext = {v[WIDTH-1], v};
        if (v[WIDTH-1]) begin
            abs_mag = -ext;
        end else begin
            abs_mag = ext;
        end
    endfunction

    state_t            state_r;
    state_t            state_nx_s;
    logic [CW-1:0]     cnt_r;
    logic [PW-1:0]     mcand_r;
    logic [WIDTH:0]    mplier_r;
    logic [PW-1:0]     psum_r;
    logic              neg_r;
    logic              is_mac_r;
    logic [WIDTH-1:0]  prod_r;
    logic              mul_valid_r;
    logic [PW-1:0]     mac_prod_r;
    logic [WIDTH-1:0]  acc_r;
    logic [WIDTH-1:0]  acc_nx_s;
    logic              start_mul_s;
    logic              start_mac_s;
    logic [WIDTH-1:0]  op_a_s;
    logic [WIDTH-1:0]  op_b_s;
    logic [PW-1:0]     prod_full_s;
    logic              unused_en_get_mac_s;

    assign unused_en_get_mac_s = EN_get_mac;

    // Accept decode and next-state selection.
    always_comb begin
        state_nx_s  = state_r;
        start_mul_s = 1'b0;
        start_mac_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (EN_multiply && !mul_valid_r) begin
                    start_mul_s = 1'b1;
                    state_nx_s  = ST_MUL;
                end else if (EN_mac) begin
                    start_mac_s = 1'b1;
                    state_nx_s  = ST_MUL;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (cnt_r == CNT_LAST) begin
                    state_nx_s = is_mac_r ? ST_ACC : ST_IDLE;
                end else begin
                    state_nx_s = ST_MUL;
                end
            end
            ST_ACC:  state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Operand selection, signed product and accumulator update value.
    always_comb begin
        op_a_s      = mac_a;
        op_b_s      = mac_b;
        prod_full_s = psum_r;
        acc_nx_s    = acc_r;
        if (start_mul_s) begin
            op_a_s = multiply_a;
            op_b_s = multiply_b;
        end else begin
            op_a_s = mac_a;
            op_b_s = mac_b;
        end
        if (neg_r) begin
            prod_full_s = -psum_r;
        end else begin
            prod_full_s = psum_r;
        end
`ifdef HERALD_MAC_SAT_EN
        begin
            logic [SW-1:0] sum_s;
            sum_s = {{(WIDTH + 1){acc_r[WIDTH-1]}}, acc_r} + {mac_prod_r[PW-1], mac_prod_r};
            if ($signed(sum_s) > $signed(SAT_MAX)) begin
                acc_nx_s = {1'b0, {(WIDTH - 1){1'b1}}};
            end else if ($signed(sum_s) < $signed(SAT_MIN)) begin
                acc_nx_s = {1'b1, {(WIDTH - 1){1'b0}}};
            end else begin
                acc_nx_s = sum_s[WIDTH-1:0];
            end
        end
`else
        acc_nx_s = acc_r + mac_prod_r;
`endif
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Shift-add engine; the cycle after the last bit applies the sign.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r      <= {CW{1'b0}};
            mcand_r    <= {PW{1'b0}};
            mplier_r   <= {(WIDTH + 1){1'b0}};
            psum_r     <= {PW{1'b0}};
            neg_r      <= 1'b0;
            is_mac_r   <= 1'b0;
            prod_r     <= {WIDTH{1'b0}};
            mac_prod_r <= {PW{1'b0}};
        end else if (start_mul_s || start_mac_s) begin
            mcand_r  <= PW'(abs_mag(op_a_s));
            mplier_r <= abs_mag(op_b_s);
            neg_r    <= op_a_s[WIDTH-1] ^ op_b_s[WIDTH-1];
            psum_r   <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            is_mac_r <= start_mac_s;
        end else if (state_r == ST_MUL) begin
            if (cnt_r != CNT_LAST) begin
                if (mplier_r[0]) begin
                    psum_r <= psum_r + mcand_r;
                end
                mcand_r  <= {mcand_r[PW-2:0], 1'b0};
                mplier_r <= {1'b0, mplier_r[WIDTH:1]};
                cnt_r    <= cnt_r + CNT_ONE;
            end else if (is_mac_r) begin
                mac_prod_r <= prod_full_s;
            end else begin
                prod_r <= prod_full_s[WIDTH-1:0];
            end
        end
    end

    // Product-valid flag: set on multiply completion, cleared by consume.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mul_valid_r <= 1'b0;
        end else if (state_r == ST_MUL && cnt_r == CNT_LAST && !is_mac_r) begin
            mul_valid_r <= 1'b1;
        end else if (EN_get_multiply && mul_valid_r) begin
            mul_valid_r <= 1'b0;
        end
    end

    // Accumulator: clear is taken before a same-cycle mac accept.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_r <= {WIDTH{1'b0}};
        end else if (state_r == ST_IDLE && EN_clear_accumulator) begin
            acc_r <= {WIDTH{1'b0}};
        end else if (state_r == ST_ACC) begin
            acc_r <= acc_nx_s;
        end
    end

    assign get_multiply          = prod_r;
    assign get_mac               = acc_r;
    assign RDY_get_multiply      = mul_valid_r;
    assign RDY_multiply          = (state_r == ST_IDLE) && !mul_valid_r;
    assign RDY_mac               = (state_r == ST_IDLE);
    assign RDY_clear_accumulator = (state_r == ST_IDLE);
    assign RDY_get_mac           = (state_r == ST_IDLE);
    assign busy                  = (state_r != ST_IDLE);

endmodule
